// File: rtl/io_devices_pkg.sv
// io_devices_pkg: shared definitions for the memory-mapped I/O unit.
//   - Device register addresses inside the 0xF000-0xF03F window.
//   - Read value returned for unmapped addresses.
//   - Register-select enum and the address decoder used by the top level.
package io_devices_pkg;

  localparam logic [15:0] IO_BASE       = 16'hF000;
  localparam logic [15:0] IO_HEX        = 16'hF000;
  localparam logic [15:0] IO_LEDR       = 16'hF004;
  localparam logic [15:0] IO_LEDG       = 16'hF008;
  localparam logic [15:0] IO_KEY        = 16'hF010;
  localparam logic [15:0] IO_KEYEDGE    = 16'hF014;
  localparam logic [15:0] IO_SW         = 16'hF020;
  localparam logic [15:0] IO_TIMER      = 16'hF030;
  localparam logic [15:0] IO_DEFAULT_RD = 16'hDEAD;

  typedef enum logic [3:0] {
    SEL_NONE,     // outside the device window
    SEL_HEX,
    SEL_LEDR,
    SEL_LEDG,
    SEL_KEY,
    SEL_KEYEDGE,
    SEL_SW,
    SEL_TIMER,
    SEL_OTHER     // inside the window but no register there
  } io_sel_e;

  // The window is the 64-byte block starting at IO_BASE; inside it only the
  // exact register addresses select a device.
  function automatic io_sel_e io_decode(input logic [15:0] addr);
    io_sel_e sel;
    if (addr[15:6] != IO_BASE[15:6]) begin
      sel = SEL_NONE;
    end else begin
      case (addr)
        IO_HEX:     sel = SEL_HEX;
        IO_LEDR:    sel = SEL_LEDR;
        IO_LEDG:    sel = SEL_LEDG;
        IO_KEY:     sel = SEL_KEY;
        IO_KEYEDGE: sel = SEL_KEYEDGE;
        IO_SW:      sel = SEL_SW;
        IO_TIMER:   sel = SEL_TIMER;
        default:    sel = SEL_OTHER;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/io_devices_if.sv
// io_devices_if: processor data-path bus as seen by the I/O unit.
//   addr  : byte address (MAR value)
//   wdata : write data
//   we    : write strobe
//   rdata : combinational read data from the device side
//   hit   : address falls inside the device window
// master = processor side, slave = io_devices side.
interface io_devices_if #(
  parameter int unsigned DBITS = 16
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic [DBITS-1:0] rdata;
  logic             hit;

  modport master (output addr, output wdata, output we, input rdata, input hit);
  modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer plus stability-counter debouncer.
//   clk, reset_n : clock, synchronous active-low reset
//   din_i        : raw asynchronous input bus
//   deb_o        : debounced value, updates 2+DEB_CYCLES cycles after a pin change
//   fall_o       : per-bit 1->0 transition of deb_o at the coming clock edge
module io_debounce #(
  parameter int unsigned     WIDTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned     DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] deb_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // sync1_q is the value sync2_q takes next cycle, so comparing the two
  // detects a change of the synchronized output one cycle early; this keeps
  // the pin-to-debounced latency at exactly 2+DEB_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      deb_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      deb_q   <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o  = deb_q;
  assign fall_o = deb_q & ~deb_d;

endmodule

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: hex nibble to seven-segment drive, active-low.
//   nibble_i : value 0-F
//   seg_o    : {g,f,e,d,c,b,a}, 0 = segment lit
module seven_seg_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/io_devices.sv
// io_devices: memory-mapped I/O unit for the 0xF000-0xF03F window.
//   clk, reset_n       : clock, synchronous active-low reset
//   bus (slave)        : addr/wdata/we in, rdata/hit out (rdata combinational)
//   key_in[3:0]        : raw KEY pins, active-low, debounced + press capture
//   sw_in[9:0]         : raw SW pins, debounced
//   ledr[9:0], ledg[7:0] : LED registers
//   hex0..hex3         : seven-segment drives of the HEX register nibbles
// Also holds a free-running timer incremented every TICK_DIV cycles.
module io_devices
  import io_devices_pkg::*;
#(
  parameter int unsigned DBITS      = 16,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned TICK_DIV   = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  io_devices_if.slave bus,
  input  logic [3:0] key_in,
  input  logic [9:0] sw_in,
  output logic [9:0] ledr,
  output logic [7:0] ledg,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [15:0]   hex_q, hex_d;
  logic [9:0]    ledr_q, ledr_d;
  logic [7:0]    ledg_q, ledg_d;
  logic [15:0]   timer_q, timer_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    ecap_q, ecap_d;

  logic [3:0]    key_deb, key_fall;
  logic [9:0]    sw_deb, sw_fall_unused;
  io_sel_e       sel;
  logic [15:0]   rd16;

  assign sel = io_decode(bus.addr[15:0]);

  io_debounce #(
    .WIDTH      (4),
    .RESET_VAL  (4'hF),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .din_i   (key_in),
    .deb_o   (key_deb),
    .fall_o  (key_fall)
  );

  io_debounce #(
    .WIDTH      (10),
    .RESET_VAL  (10'h000),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .din_i   (sw_in),
    .deb_o   (sw_deb),
    .fall_o  (sw_fall_unused)
  );

  always_comb begin
    rd16 = IO_DEFAULT_RD;
    case (sel)
      SEL_HEX:     rd16 = hex_q;
      SEL_LEDR:    rd16 = {6'b0, ledr_q};
      SEL_LEDG:    rd16 = {8'b0, ledg_q};
      SEL_KEY:     rd16 = {12'b0, key_deb};
      SEL_KEYEDGE: rd16 = {12'b0, ecap_q};
      SEL_SW:      rd16 = {6'b0, sw_deb};
      SEL_TIMER:   rd16 = timer_q;
      default:     rd16 = IO_DEFAULT_RD;
    endcase
    bus.rdata = DBITS'(rd16);
    bus.hit   = (sel != SEL_NONE);
  end

  always_comb begin
    hex_d   = hex_q;
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    timer_d = timer_q;
    tick_d  = tick_q;
    ecap_d  = ecap_q;

    if (tick_q == TW'(TICK_DIV - 1)) begin
      tick_d  = '0;
      timer_d = timer_q + 16'd1;
    end else begin
      tick_d  = tick_q + TW'(1);
    end

    // sel is SEL_NONE outside the window, so no write can land there.
    if (bus.we) begin
      case (sel)
        SEL_HEX:     hex_d  = bus.wdata[15:0];
        SEL_LEDR:    ledr_d = bus.wdata[9:0];
        SEL_LEDG:    ledg_d = bus.wdata[7:0];
        SEL_KEYEDGE: ecap_d = ecap_q & ~bus.wdata[3:0];
        SEL_TIMER: begin
          timer_d = bus.wdata[15:0];
          tick_d  = '0;
        end
        default: ;
      endcase
    end

    // New presses are OR'd in after the clear so a coincident press survives.
    ecap_d = ecap_d | key_fall;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hex_q   <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
      timer_q <= '0;
      tick_q  <= '0;
      ecap_q  <= '0;
    end else begin
      hex_q   <= hex_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      timer_q <= timer_d;
      tick_q  <= tick_d;
      ecap_q  <= ecap_d;
    end
  end

  assign ledr = ledr_q;
  assign ledg = ledg_q;

  seven_seg_decoder u_hex0 (.nibble_i(hex_q[3:0]),   .seg_o(hex0));
  seven_seg_decoder u_hex1 (.nibble_i(hex_q[7:4]),   .seg_o(hex1));
  seven_seg_decoder u_hex2 (.nibble_i(hex_q[11:8]),  .seg_o(hex2));
  seven_seg_decoder u_hex3 (.nibble_i(hex_q[15:12]), .seg_o(hex3));

endmodule

// File: tb/tb_io_devices.sv
// tb_io_devices: self-checking bench for io_devices with a behavioural model.
module tb_io_devices;

  localparam int DEB = 16;
  localparam int TD  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_in;
  logic [9:0] sw_in;
  logic [9:0] ledr;
  logic [7:0] ledg;
  logic [6:0] hex0, hex1, hex2, hex3;

  io_devices_if #(.DBITS(16)) bus ();

  io_devices #(
    .DBITS      (16),
    .DEB_CYCLES (DEB),
    .TICK_DIV   (TD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .key_in  (key_in),
    .sw_in   (sw_in),
    .ledr    (ledr),
    .ledg    (ledg),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Active-high segment patterns {g..a}; the display drives their inverse.
  logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [15:0] m_hex, m_timer;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic [3:0]  m_ec;
  int          m_tick;
  logic [3:0]  k_last, k_deb;
  int          k_run;
  logic [9:0]  s_last, s_deb;
  int          s_run;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    return ~seg_on[n];
  endfunction

  task automatic m_reset();
    m_hex = '0; m_ledr = '0; m_ledg = '0; m_timer = '0; m_tick = 0; m_ec = '0;
    k_last = 4'hF; k_deb = 4'hF; k_run = 1;
    s_last = '0;   s_deb = '0;   s_run = 1;
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a[15:6] != 10'h3C0) return 16'hDEAD;
    case (a)
      16'hF000: return m_hex;
      16'hF004: return {6'b0, m_ledr};
      16'hF008: return {8'b0, m_ledg};
      16'hF010: return {12'b0, k_deb};
      16'hF014: return {12'b0, m_ec};
      16'hF020: return {6'b0, s_deb};
      16'hF030: return m_timer;
      default:  return 16'hDEAD;
    endcase
  endfunction

  // One clock edge of the reference: a debounced bus follows the pins once
  // they have been sampled identical on DEB+1 consecutive edges.
  task automatic model_step();
    logic [3:0] kd_new, clr;
    logic [9:0] sd_new;
    if (!reset_n) begin
      m_reset();
    end else begin
      kd_new = (k_run >= DEB + 1) ? k_last : k_deb;
      sd_new = (s_run >= DEB + 1) ? s_last : s_deb;
      clr = (bus.we && bus.addr == 16'hF014) ? bus.wdata[3:0] : 4'h0;
      m_ec = (m_ec & ~clr) | (k_deb & ~kd_new);
      k_deb = kd_new;
      s_deb = sd_new;
      if (key_in == k_last) k_run = (k_run < 1000) ? k_run + 1 : k_run;
      else begin k_last = key_in; k_run = 1; end
      if (sw_in == s_last) s_run = (s_run < 1000) ? s_run + 1 : s_run;
      else begin s_last = sw_in; s_run = 1; end
      m_tick = (m_tick + 1) % TD;
      if (m_tick == 0) m_timer = m_timer + 16'd1;
      if (bus.we) begin
        case (bus.addr)
          16'hF000: m_hex  = bus.wdata;
          16'hF004: m_ledr = bus.wdata[9:0];
          16'hF008: m_ledg = bus.wdata[7:0];
          16'hF030: begin m_timer = bus.wdata; m_tick = 0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("outs", {hex3, hex2, hex1, hex0, ledr, ledg},
          {seg(m_hex[15:12]), seg(m_hex[11:8]), seg(m_hex[7:4]), seg(m_hex[3:0]), m_ledr, m_ledg});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    cycle();
    bus.we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a);
    bus.addr = a; bus.we = 1'b0;
    #1;
    check(tag, bus.rdata, m_read(a));
    check({tag, "_hit"}, bus.hit, a[15:6] == 10'h3C0);
  endtask

  task automatic rd_const(input string tag, input logic [15:0] a, input logic [15:0] exp);
    rd_check(tag, a);
    check({tag, "_c"}, bus.rdata, exp);
  endtask

  initial begin
    logic [15:0] ra;
    int op;
    reset_n = 1'b0; key_in = 4'hF; sw_in = '0;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
    m_reset();

    // Reset values
    cycles(2);
    reset_n = 1'b1;
    rd_const("rst_hex", 16'hF000, 16'h0000);
    rd_const("rst_ledr", 16'hF004, 16'h0000);
    rd_const("rst_ledg", 16'hF008, 16'h0000);
    rd_const("rst_timer", 16'hF030, 16'h0000);
    rd_const("rst_key", 16'hF010, 16'h000F);
    rd_const("rst_nohit", 16'hF040, 16'hDEAD);
    check("rst_nohit_hit", bus.hit, 1'b0);

    // Display and LEDs
    wr(16'hF000, 16'h12AF);
    check("hex0_F", hex0, 7'b0001110);
    check("hex1_A", hex1, 7'b0001000);
    check("hex2_2", hex2, 7'b0100100);
    check("hex3_1", hex3, 7'b1111001);
    rd_const("rd_hex", 16'hF000, 16'h12AF);
    wr(16'hF004, 16'hFFFF);
    check("ledr_all", ledr, 10'h3FF);
    rd_const("rd_ledr", 16'hF004, 16'h03FF);
    wr(16'hF008, 16'hFFA5);
    rd_const("rd_ledg", 16'hF008, 16'h00A5);
    wr(16'hF00C, 16'h5555);
    rd_const("rd_hole", 16'hF00C, 16'hDEAD);
    wr(16'hF010, 16'h0000);
    rd_const("key_ro", 16'hF010, 16'h000F);

    // KEY glitch, debounce latency, edge capture, W1C
    key_in = 4'hB; cycles(5); key_in = 4'hF; cycles(20);
    rd_const("glitch_key", 16'hF010, 16'h000F);
    rd_const("glitch_edge", 16'hF014, 16'h0000);
    key_in = 4'hB; cycles(DEB + 1);
    rd_const("key_early", 16'hF010, 16'h000F);
    cycle();
    rd_const("key_deb", 16'hF010, 16'h000B);
    rd_const("key_edge", 16'hF014, 16'h0004);
    wr(16'hF014, 16'h0004);
    rd_const("edge_w1c", 16'hF014, 16'h0000);
    key_in = 4'hF; cycles(DEB + 4);
    rd_const("rel_edge", 16'hF014, 16'h0000);
    key_in = 4'hB; cycles(DEB + 1);
    wr(16'hF014, 16'h0004);
    rd_const("set_wins", 16'hF014, 16'h0004);
    key_in = 4'hF; cycles(DEB + 4);

    // SW debounce latency
    sw_in = 10'h2A5; cycles(DEB + 1);
    rd_const("sw_early", 16'hF020, 16'h0000);
    cycle();
    rd_const("sw_deb", 16'hF020, 16'h02A5);

    // Timer
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    cycles(4);
    rd_const("timer_1", 16'hF030, 16'h0001);
    cycles(8);
    rd_const("timer_3", 16'hF030, 16'h0003);
    wr(16'hF030, 16'hFFFF);
    cycles(4);
    rd_const("timer_wrap", 16'hF030, 16'h0000);
    cycles(3);
    wr(16'hF030, 16'h1234);
    rd_const("timer_wr_wins", 16'hF030, 16'h1234);

    // Reset mid-debounce and mid-tick
    wr(16'hF000, 16'hBEEF);
    sw_in = 10'h155; key_in = 4'h7;
    cycles(10);
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    rd_const("mid_sw", 16'hF020, 16'h0000);
    rd_const("mid_key", 16'hF010, 16'h000F);
    rd_const("mid_edge", 16'hF014, 16'h0000);
    rd_const("mid_hex", 16'hF000, 16'h0000);
    cycles(DEB - 6);
    rd_const("mid_nocommit", 16'hF020, 16'h0000);
    cycles(10);
    rd_check("mid_recommit", 16'hF020);

    // Randomized traffic against the model
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 7) == 0) key_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 9))
        0: ra = 16'hF000;  1: ra = 16'hF004;  2: ra = 16'hF008;  3: ra = 16'hF010;
        4: ra = 16'hF014;  5: ra = 16'hF020;  6: ra = 16'hF030;
        7: ra = 16'hF000 + 16'($urandom_range(0, 63));
        8: ra = 16'($urandom_range(0, 65535));
        default: ra = 16'hF03F + 16'($urandom_range(1, 3));
      endcase
      op = $urandom_range(0, 9);
      if (op < 4) begin
        rd_check("rand_rd", ra);
        cycle();
      end else if (op < 7) begin
        wr(ra, 16'($urandom_range(0, 65535)));
      end else begin
        cycles($urandom_range(1, 6));
      end
    end
    rd_check("end_key", 16'hF010);
    rd_check("end_sw", 16'hF020);
    rd_check("end_edge", 16'hF014);
    rd_check("end_timer", 16'hF030);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_devices.md
Name: io_devices

Overview:
- Memory-mapped I/O unit on the processor data path, alongside the 4K-word RAM. It serves every access the RAM does not.
- Decodes the latched memory address (MAR) for the 0xF000–0xF03F device window.
- Output devices: HEX display, red LEDs, green LEDs, timer.
- Input devices: KEY and SW, each synchronized and debounced; KEY also has press edge-capture.
- The processor muxes io_devices read data onto the bus in place of RAM output whenever the device window is addressed.

Parameters:
- DBITS, 16, data/address width.
- DEB_CYCLES, 16, consecutive stable cycles required before a synchronized input is accepted.
- TICK_DIV, 50000, clock cycles per timer increment (1 ms at 50 MHz).

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- addr, in, DBITS, byte address (MAR value).
- wdata, in, DBITS, write data (bus value).
- we, in, 1, write strobe; acts only when the window is hit.
- rdata, out, DBITS, read data, combinational from addr.
- hit, out, 1, addr is inside 0xF000–0xF03F.
- key_in, in, 4, raw KEY pins, active-low.
- sw_in, in, 10, raw SW pins.
- ledr, out, 10, red LEDs.
- ledg, out, 8, green LEDs.
- hex0, hex1, hex2, hex3, out, 7 each, seven-segment drives, active-low; hex0 shows nibble [3:0].

Behaviour:

Clocking and reset:
- Single clock domain. All state updates on posedge clk.
- reset_n=0 at a clock edge forces: hex_reg=0, ledr=0, ledg=0, timer=0, tick counter=0, edge_cap=0, key sync/debounced=4'hF, sw sync/debounced=0, debounce counters=0.
- Reset asserted mid-debounce or mid-tick discards the partial count.

Address map (addr[15:6]==10'h3C0 gives hit=1):
- F000 HEX, R/W, 16 bits.
- F004 LEDR, R/W, bits [9:0]; upper bits read 0.
- F008 LEDG, R/W, bits [7:0].
- F010 KEY, RO: debounced level, active-low raw sense (pressed=0), bits [3:0].
- F014 KEYEDGE, R/W1C, bits [3:0].
- F020 SW, RO: debounced, bits [9:0].
- F030 TIMER, R/W, 16 bits.

Read/write rules:
- Any other address inside the window reads 16'hDEAD. Writes to it, or to read-only registers, are ignored.
- hit=0: rdata=16'hDEAD and writes are ignored.
- Reads are combinational with zero latency, like the RAM.
- Writes take effect at the clock edge where we=1 and hit=1; the new value is readable the next cycle.

Input path (per bus, KEY and SW separately):
- 2-flop synchronizer feeds a stability counter.
- Counter resets whenever the sync output differs from its previous value.
- When the counter reaches DEB_CYCLES-1 with the input still stable, the debounced register loads the sync value.
- Latency from pin change to debounced update: 2 + DEB_CYCLES cycles.
- Glitches shorter than DEB_CYCLES are never seen.

KEY edge capture:
- edge_cap[i] sets when debounced KEY[i] goes 1→0 (press).
- A write to F014 clears every bit set in wdata[3:0].
- Set and clear of the same bit in the same cycle: set wins.

Timer:
- Tick counter runs 0..TICK_DIV-1. At the wrap, timer increments; 0xFFFF wraps to 0.
- A CPU write to F030 loads wdata and zeroes the tick counter. It wins over a coincident increment.

Display:
- hexN = seven-segment decode of hex_reg nibble N, for glyphs 0–9 and A–F, active-low.
- Updates combinationally from hex_reg.

Decomposition:
- Shared package holds:
  - address constants IO_HEX, IO_LEDR, IO_LEDG, IO_KEY, IO_KEYEDGE, IO_SW, IO_TIMER;
  - IO_BASE=16'hF000;
  - the default read value 16'hDEAD.
- Sub-module seven_seg_decoder: 4-bit in, 7-bit active-low out, instantiated four times.
- The debouncer is written once as a parameterized-width sub-module io_debounce, used for KEY (width 4, reset 4'hF) and SW (width 10, reset 0).

Test Plan:
- Reset, then read F000/F004/F008/F030 → 0, F010 → 0x000F, F040 → 0xDEAD with hit=0.
- Write F000=0x12AF → hex3..hex0 = 1,2,A,F glyphs (hex0=7'b0001110); read F000 → 0x12AF. Write F004=0xFFFF → ledr=10'h3FF, read → 0x03FF.
- key_in[2] low for 5 cycles → no change. Hold low for 2+DEB_CYCLES cycles → F010 reads 0x000B and F014 reads 0x0004. Write F014=0x0004 → reads 0. Press a key in the same cycle as its W1C → bit stays 1.
- sw_in=10'h2A5 held → F020 reads 0x02A5 exactly 2+DEB_CYCLES cycles later, not earlier.
- TICK_DIV=4: after reset, timer reads 1 after 4 cycles and 3 after 12. Write F030=0xFFFF, wait 4 cycles → 0x0000. Write coinciding with a tick → written value held.
- reset_n low for one cycle mid-debounce and mid-tick → all registers return to reset values; the partial debounce is not committed.
